muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Parametrised multi-cycle multiply/divide unit for the accumulator datapath. It takes the accumulator operand and the buffer-register operand and runs a sequential shift-add multiply or restoring divide, signed or unsigned. It returns the low word or quotient for ACC and the high word or remainder for MR, using a start/busy/done handshake driven by the control unit. It replaces the single-cycle multiply path in the ALU, and adds division and signed modes.

## Interface
- `WIDTH`, default 16: operand and result width; legal range 4..64.
- `clk`  in  1  system clock, rising-edge.
- `rst`  in  1  reset, asynchronous, active-low.
- `start`  in  1  request; sampled only in IDLE.
- `op`  in  2  operation: 00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- `a_in`  in  WIDTH  multiplicand or dividend (from ACC).
- `b_in`  in  WIDTH  multiplier or divisor (from BR).
- `busy`  out  1  high from the cycle after an accepted start until `done`, inclusive.
- `done`  out  1  one-cycle pulse; results valid on this cycle.
- `acc_res`  out  WIDTH  low product word or quotient.
- `mr_res`  out  WIDTH  high product word or remainder.
- `div_zero`  out  1  last operation was a divide by zero.
- `ovf`  out  1  last operation was a DIVS of most-negative by −1.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `start`=1:
  - Latch `op`, `a_in`, `b_in`.
  - Signed ops store the operand magnitudes plus the result signs.
    - Product sign = sign(a) XOR sign(b).
    - Quotient sign = sign(a) XOR sign(b).
    - Remainder sign = sign(a).
  - Clear the iteration counter (width $clog2(WIDTH+1)).
  - Go to CALC.
  - Exception: divide with `b_in`=0 goes straight to DONE.
- IDLE, `start`=0: hold state.
- CALC runs exactly WIDTH iterations, one per cycle.
  - Multiply: a 2·WIDTH-bit shift-add step, LSB-first.
  - Divide: a restoring step, MSB-first, using a WIDTH+1-bit partial remainder.
  - When the counter reaches WIDTH−1, go to FIX.
- FIX: apply the two's-complement negation selected by the latched signs. Write `acc_res`/`mr_res`. Go to DONE.
- DONE: `done`=1 for this one cycle, then go to IDLE.
- Arithmetic rules:
  - Signed division truncates toward zero.
  - The remainder takes the sign of the dividend.
  - A MULS product is the full 2·WIDTH-bit signed result.
- Divide by zero:
  - `acc_res` = all ones.
  - `mr_res` = the original `a_in`.
  - `div_zero`=1, `ovf`=0.
- DIVS of most-negative by all-ones:
  - Computed normally through CALC/FIX.
  - Result: `acc_res` = most-negative, `mr_res`=0, `ovf`=1.
- Flags are computed at accept time and updated together with the results.
- Results and flags hold until the next accepted operation produces new ones.
- `start` while not in IDLE is ignored. No queueing, no error.
- `op` and operand changes after acceptance have no effect.

## Timing
- Reset state: state=IDLE; `busy`, `done`, `div_zero`, `ovf` = 0; `acc_res`, `mr_res` = 0.
- Reset asserted mid-operation aborts immediately to the reset state. No `done` is produced.
- Start accepted on edge t:
  - CALC occupies edges t+1 .. t+WIDTH.
  - FIX occupies edge t+WIDTH+1.
  - `done` is high during cycle t+WIDTH+2.
  - Total latency: WIDTH+2 cycles.
- Divide by zero: `done` is high during cycle t+1 (latency 1).
- Back-to-back: a `start` held high during the `done` cycle is not accepted, because the state is DONE. It is accepted on the next cycle (IDLE). Minimum issue interval is WIDTH+3 cycles.
- `busy` is a registered output. It is high in CALC, FIX and DONE, and low in IDLE.
- All outputs are registered. There is no combinational path from inputs to outputs.

## Structure
- Shared package `muldiv_pkg` holds:
  - the `op` encoding constants (OP_MULU, OP_MULS, OP_DIVU, OP_DIVS);
  - the state enum (S_IDLE, S_CALC, S_FIX, S_DONE).
- The control unit imports the same op constants to drive `op`.
- Single module. No sub-module is needed: the counter, the shift register and the add/subtract step are all inline.

## Test plan
- WIDTH=16, MULU 0x1234×0x0010 → `acc_res`=0x2340, `mr_res`=0x0001, `done` exactly 18 cycles after start, `busy` high for the 18 cycles that follow the start edge (CALC, FIX, DONE).
- MULS 0xFFFD(−3)×0x0005 → `acc_res`=0xFFF1, `mr_res`=0xFFFF. MULS 0x8000×0x8000 → `acc_res`=0x0000, `mr_res`=0x4000.
- DIVU 100/7 → `acc_res`=0x000E, `mr_res`=0x0002. DIVS 0xFFF9(−7)/0x0002 → `acc_res`=0xFFFD, `mr_res`=0xFFFF.
- DIVU 0x00AB/0 → `done` on the next cycle, `div_zero`=1, `acc_res`=0xFFFF, `mr_res`=0x00AB. DIVS 0x8000/0xFFFF → `acc_res`=0x8000, `mr_res`=0, `ovf`=1.
- `start` pulsed during CALC with different operands → ignored, and the first result is unchanged. `start` held through `done` → a second operation is accepted the cycle after `done`.
- `rst` asserted at iteration 5 → all outputs go to 0 immediately and no `done` is produced. A fresh DIVU 100/7 after release → correct result.

Source files
------------

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op encodings and FSM states shared by muldiv_unit and the control unit
package muldiv_pkg;
    localparam logic [1:0] OP_MULU = 2'b00;
    localparam logic [1:0] OP_MULS = 2'b01;
    localparam logic [1:0] OP_DIVU = 2'b10;
    localparam logic [1:0] OP_DIVS = 2'b11;
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_e;
endpackage

// File: rtl/muldiv_unit.sv
// muldiv_unit: sequential shift-add multiply / restoring divide, signed or unsigned,
// operating on magnitudes with sign fix-up applied in a final FIX cycle
module muldiv_unit
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] acc_res,
    output logic [WIDTH-1:0] mr_res,
    output logic             div_zero,
    output logic             ovf
);
    localparam int CW = $clog2(WIDTH + 1);
    state_e state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, m_q, m_d, acc_d, mr_d;
    logic div_q, div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d, ovf_p_q, ovf_p_d, dz_d, ovf_d;
    logic is_div, sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_mag, b_mag;
    logic [WIDTH:0] sum, sh, diff;
    logic [2*WIDTH-1:0] prod;
    assign is_div = (op == OP_DIVU) || (op == OP_DIVS);
    assign sgn    = (op == OP_MULS) || (op == OP_DIVS);
    assign a_neg  = sgn & a_in[WIDTH-1];
    assign b_neg  = sgn & b_in[WIDTH-1];
    assign a_mag  = a_neg ? -a_in : a_in;
    assign b_mag  = b_neg ? -b_in : b_in;
    // lo_q holds multiplier / dividend-then-quotient, hi_q the high product word / remainder
    assign sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, m_q} : '0);
    assign sh   = {hi_q, lo_q[WIDTH-1]};
    assign diff = sh - {1'b0, m_q};
    assign prod = {hi_q, lo_q};
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        m_d      = m_q;
        div_d    = div_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        ovf_p_d  = ovf_p_q;
        acc_d    = acc_res;
        mr_d     = mr_res;
        dz_d     = div_zero;
        ovf_d    = ovf;
        case (state_q)
            S_IDLE: if (start) begin
                div_d    = is_div;
                cnt_d    = '0;
                hi_d     = '0;
                lo_d     = a_mag;
                m_d      = b_mag;
                neg_lo_d = a_neg ^ b_neg;
                neg_hi_d = is_div ? a_neg : (a_neg ^ b_neg);
                ovf_p_d  = is_div & sgn & (a_in == {1'b1, {(WIDTH-1){1'b0}}}) & (&b_in);
                state_d  = S_CALC;
                if (is_div && b_in == '0) begin
                    acc_d   = '1;
                    mr_d    = a_in;
                    dz_d    = 1'b1;
                    ovf_d   = 1'b0;
                    state_d = S_DONE;
                end
            end
            S_CALC: begin
                hi_d    = div_q ? (diff[WIDTH] ? sh[WIDTH-1:0] : diff[WIDTH-1:0]) : sum[WIDTH:1];
                lo_d    = div_q ? {lo_q[WIDTH-2:0], ~diff[WIDTH]} : {sum[0], lo_q[WIDTH-1:1]};
                cnt_d   = cnt_q + 1'b1;
                state_d = (cnt_q == CW'(WIDTH - 1)) ? S_FIX : S_CALC;
            end
            S_FIX: begin
                if (div_q) begin
                    acc_d = neg_lo_q ? -lo_q : lo_q;
                    mr_d  = neg_hi_q ? -hi_q : hi_q;
                end else begin
                    {mr_d, acc_d} = neg_lo_q ? -prod : prod;
                end
                dz_d    = 1'b0;
                ovf_d   = ovf_p_q;
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            m_q      <= '0;
            div_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            ovf_p_q  <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            acc_res  <= '0;
            mr_res   <= '0;
            div_zero <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            m_q      <= m_d;
            div_q    <= div_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            ovf_p_q  <= ovf_p_d;
            busy     <= state_d != S_IDLE;
            done     <= state_d == S_DONE;
            acc_res  <= acc_d;
            mr_res   <= mr_d;
            div_zero <= dz_d;
            ovf      <= ovf_d;
        end
    end
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed vectors for muldiv_unit at WIDTH=16
module tb_muldiv_unit;
    import muldiv_pkg::*;
    localparam int W = 16;
    logic clk = 1'b0, rst = 1'b0, start = 1'b0;
    logic [1:0] op = 2'b00;
    logic [W-1:0] a_in = '0, b_in = '0;
    logic busy, done, div_zero, ovf;
    logic [W-1:0] acc_res, mr_res;
    int passed = 0, total = 0;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a_in(a_in), .b_in(b_in),
        .busy(busy), .done(done), .acc_res(acc_res), .mr_res(mr_res),
        .div_zero(div_zero), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic issue(input logic [1:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op = o; a_in = a; b_in = b; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic wait_done(output int lat, output int bc);
        lat = 0; bc = 0;
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (busy) bc++;
            if (done) lat = n;
        end
    endtask

    task automatic test_reset;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if ({busy, done, div_zero, ovf} !== 4'b0000) $display("FAIL reset_flags got %b want 0000", {busy, done, div_zero, ovf}); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h0) $display("FAIL reset_results got %h want 00000000", {acc_res, mr_res}); else passed++;
        rst = 1'b1;
    endtask

    task automatic test_mulu;
        int lat, bc;
        issue(OP_MULU, 16'h1234, 16'h0010);
        wait_done(lat, bc);
        total++; if (lat !== 18) $display("FAIL mulu_latency got %0d want 18", lat); else passed++;
        total++; if (bc !== 18) $display("FAIL mulu_busy_cycles got %0d want 18", bc); else passed++;
        total++; if (acc_res !== 16'h2340) $display("FAIL mulu_acc got %h want 2340", acc_res); else passed++;
        total++; if (mr_res !== 16'h0001) $display("FAIL mulu_mr got %h want 0001", mr_res); else passed++;
        @(negedge clk);
        total++; if ({busy, done} !== 2'b00) $display("FAIL mulu_idle_after got %b want 00", {busy, done}); else passed++;
        total++; if ({mr_res, acc_res} !== 32'h0001_2340) $display("FAIL mulu_hold got %h want 00012340", {mr_res, acc_res}); else passed++;
    endtask

    task automatic test_muls;
        int lat, bc;
        issue(OP_MULS, 16'hFFFD, 16'h0005);
        wait_done(lat, bc);
        total++; if ({mr_res, acc_res} !== 32'hFFFF_FFF1) $display("FAIL muls_neg got %h want FFFFFFF1", {mr_res, acc_res}); else passed++;
        issue(OP_MULS, 16'h8000, 16'h8000);
        wait_done(lat, bc);
        total++; if ({mr_res, acc_res} !== 32'h4000_0000) $display("FAIL muls_minmin got %h want 40000000", {mr_res, acc_res}); else passed++;
        total++; if (lat !== 18) $display("FAIL muls_latency got %0d want 18", lat); else passed++;
    endtask

    task automatic test_div;
        int lat, bc;
        issue(OP_DIVU, 16'd100, 16'd7);
        wait_done(lat, bc);
        total++; if ({acc_res, mr_res} !== 32'h000E_0002) $display("FAIL divu got %h want 000E0002", {acc_res, mr_res}); else passed++;
        issue(OP_DIVS, 16'hFFF9, 16'h0002);
        wait_done(lat, bc);
        total++; if ({acc_res, mr_res} !== 32'hFFFD_FFFF) $display("FAIL divs_neg got %h want FFFDFFFF", {acc_res, mr_res}); else passed++;
        total++; if ({div_zero, ovf} !== 2'b00) $display("FAIL divs_flags got %b want 00", {div_zero, ovf}); else passed++;
    endtask

    task automatic test_div_zero;
        int lat, bc;
        issue(OP_DIVU, 16'h00AB, 16'h0000);
        wait_done(lat, bc);
        total++; if (lat !== 1) $display("FAIL dz_latency got %0d want 1", lat); else passed++;
        total++; if (bc !== 1) $display("FAIL dz_busy_cycles got %0d want 1", bc); else passed++;
        total++; if ({div_zero, ovf} !== 2'b10) $display("FAIL dz_flags got %b want 10", {div_zero, ovf}); else passed++;
        total++; if ({acc_res, mr_res} !== 32'hFFFF_00AB) $display("FAIL dz_results got %h want FFFF00AB", {acc_res, mr_res}); else passed++;
    endtask

    task automatic test_divs_ovf;
        int lat, bc;
        issue(OP_DIVS, 16'h8000, 16'hFFFF);
        wait_done(lat, bc);
        total++; if (lat !== 18) $display("FAIL ovf_latency got %0d want 18", lat); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h8000_0000) $display("FAIL ovf_results got %h want 80000000", {acc_res, mr_res}); else passed++;
        total++; if ({div_zero, ovf} !== 2'b01) $display("FAIL ovf_flags got %b want 01", {div_zero, ovf}); else passed++;
    endtask

    task automatic test_start_ignored;
        int lat = 0;
        issue(OP_DIVU, 16'd100, 16'd7);
        for (int n = 1; n <= 40 && lat == 0; n++) begin
            @(negedge clk);
            if (n == 3) begin start = 1'b1; op = OP_MULU; a_in = 16'd5; b_in = 16'd9; end
            if (n == 4) start = 1'b0;
            if (done) lat = n;
        end
        total++; if (lat !== 18) $display("FAIL ign_latency got %0d want 18", lat); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h000E_0002) $display("FAIL ign_results got %h want 000E0002", {acc_res, mr_res}); else passed++;
        @(negedge clk);
        total++; if (busy !== 1'b0) $display("FAIL ign_no_second got busy=%b want 0", busy); else passed++;
    endtask

    task automatic test_back_to_back;
        int lat1 = 0, lat2 = 0;
        logic [31:0] r1 = '0;
        logic gap_busy = 1'b1;
        @(negedge clk);
        op = OP_MULU; a_in = 16'd3; b_in = 16'd4; start = 1'b1;
        @(posedge clk);
        #1 op = OP_DIVU; a_in = 16'd100; b_in = 16'd7;
        for (int n = 1; n <= 60 && lat2 == 0; n++) begin
            @(negedge clk);
            if (lat1 != 0 && n == lat1 + 1) gap_busy = busy;
            if (lat1 != 0 && n == lat1 + 2) start = 1'b0;
            if (done && lat1 == 0) begin lat1 = n; r1 = {acc_res, mr_res}; end
            else if (done) lat2 = n;
        end
        start = 1'b0;
        total++; if (lat1 !== 18) $display("FAIL b2b_first_latency got %0d want 18", lat1); else passed++;
        total++; if (r1 !== 32'h000C_0000) $display("FAIL b2b_first_results got %h want 000C0000", r1); else passed++;
        total++; if (gap_busy !== 1'b0) $display("FAIL b2b_gap_busy got %b want 0", gap_busy); else passed++;
        total++; if (lat2 !== 37) $display("FAIL b2b_second_latency got %0d want 37", lat2); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h000E_0002) $display("FAIL b2b_second_results got %h want 000E0002", {acc_res, mr_res}); else passed++;
    endtask

    task automatic test_reset_mid;
        int lat, bc;
        logic seen = 1'b0;
        issue(OP_MULU, 16'h1234, 16'h0010);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        total++; if ({busy, done, div_zero, ovf} !== 4'b0000) $display("FAIL rstmid_flags got %b want 0000", {busy, done, div_zero, ovf}); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h0) $display("FAIL rstmid_results got %h want 00000000", {acc_res, mr_res}); else passed++;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (done || busy) seen = 1'b1;
        end
        total++; if (seen !== 1'b0) $display("FAIL rstmid_no_done got activity=%b want 0", seen); else passed++;
        issue(OP_DIVU, 16'd100, 16'd7);
        wait_done(lat, bc);
        total++; if (lat !== 18) $display("FAIL rstmid_fresh_latency got %0d want 18", lat); else passed++;
        total++; if ({acc_res, mr_res} !== 32'h000E_0002) $display("FAIL rstmid_fresh_results got %h want 000E0002", {acc_res, mr_res}); else passed++;
    endtask

    initial begin
        test_reset();
        test_mulu();
        test_muls();
        test_div();
        test_div_zero();
        test_divs_ovf();
        test_start_ignored();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
